// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: owner encodings and sizes shared by the bus arbiter and its picker.
package bus_arbiter_pkg;
  localparam int OWN_W = 2;
  localparam logic [OWN_W-1:0] OWN_NONE = 2'd0;
  localparam logic [OWN_W-1:0] OWN_D = 2'd1;
  localparam logic [OWN_W-1:0] OWN_I = 2'd2;
  localparam int STARVE_W = 3;
endpackage

// File: rtl/bus_arbiter_pick.sv
// bus_arbiter_pick: combinational two-way picker; a locked owner keeps the bus while it still requests.
module bus_arbiter_pick
  import bus_arbiter_pkg::*;
(
  input  logic             i_d_req,
  input  logic             i_i_req,
  input  logic             i_lock,
  input  logic [OWN_W-1:0] i_owner_q,
  input  logic             i_prio_i,
  output logic [OWN_W-1:0] o_grant
);
  logic [OWN_W-1:0] w_arb;
  logic             w_own_req;
  always_comb begin
    w_arb = (i_d_req && !(i_i_req && i_prio_i)) ? OWN_D : i_i_req ? OWN_I : OWN_NONE;
    w_own_req = (i_owner_q == OWN_D && i_d_req) || (i_owner_q == OWN_I && i_i_req);
    o_grant = i_lock ? (w_own_req ? i_owner_q : OWN_NONE) : w_arb;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the device bus between D (load/store) and I (fetch) masters.
// ARB_ROUND_ROBIN_EN selects round-robin contention; otherwise D priority with I anti-starvation.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      d_addr,
  input  logic [3:0]       d_byte_en,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_wdata,
  output logic [31:0]      d_rdata,
  output logic             d_stall,
  input  logic [31:0]      i_addr,
  input  logic             i_read,
  output logic [31:0]      i_rdata,
  output logic             i_stall,
  output logic [31:0]      bus_addr,
  output logic [3:0]       bus_byte_en,
  output logic             bus_read,
  output logic             bus_write,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_stall,
  output logic [OWN_W-1:0] owner
);
  logic             w_d_req;
  logic             w_prio_i;
  logic             w_d_gnt;
  logic             w_i_gnt;
  logic             w_done;
  logic [OWN_W-1:0] w_pick;
  logic [OWN_W-1:0] w_grant;
  logic             r_lock;
  logic [OWN_W-1:0] r_owner_q;
  assign w_d_req = d_read | d_write;
  bus_arbiter_pick u_pick (
    .i_d_req  (w_d_req),
    .i_i_req  (i_read),
    .i_lock   (r_lock),
    .i_owner_q(r_owner_q),
    .i_prio_i (w_prio_i),
    .o_grant  (w_pick)
  );
  // Reset suppresses the grant so strobes drop in the very cycle rst_n is low.
  always_comb begin
    w_grant = rst_n ? w_pick : OWN_NONE;
    w_d_gnt = w_grant == OWN_D;
    w_i_gnt = w_grant == OWN_I;
    w_done = (w_grant != OWN_NONE) && !bus_stall;
    bus_addr = w_d_gnt ? d_addr : w_i_gnt ? i_addr : '0;
    bus_byte_en = w_d_gnt ? d_byte_en : w_i_gnt ? 4'hf : 4'h0;
    bus_read = w_d_gnt ? d_read : w_i_gnt;
    bus_write = w_d_gnt & d_write;
    bus_wdata = w_d_gnt ? d_wdata : '0;
    d_stall = w_d_gnt ? bus_stall : w_d_req;
    i_stall = w_i_gnt ? bus_stall : i_read;
    d_rdata = w_d_gnt ? bus_rdata : '0;
    i_rdata = w_i_gnt ? bus_rdata : '0;
    owner = w_grant;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
      r_owner_q <= OWN_NONE;
    end else begin
      r_lock <= (w_grant != OWN_NONE) && bus_stall;
      r_owner_q <= w_grant;
    end
  end
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_prio_i = r_last_d;
  always_ff @(posedge clk) begin
    if (!rst_n) r_last_d <= 1'b0;
    else if (w_done) r_last_d <= w_d_gnt;
  end
`else
  logic [STARVE_W-1:0] r_starve;
  assign w_prio_i = r_starve == STARVE_W'(STARVE_LIMIT);
  always_ff @(posedge clk) begin
    if (!rst_n) r_starve <= '0;
    else if (!i_read || (w_i_gnt && !bus_stall)) r_starve <= '0;
    else if (!w_i_gnt && !w_prio_i) r_starve <= r_starve + 1'b1;
  end
`endif
endmodule
